// File: rtl/load_store_unit.sv
// Load/store unit: turns a byte-addressed RISC-V load/store into one word access
// with byte-lane enables, stalls the pipeline until completion and formats load data.
// Optional feature: define MISALIGN_TRAP_EN to reject misaligned halfword/word accesses
// (cause 01); without it, low address bits that do not fit the width are ignored.
module load_store_unit #(
    parameter int unsigned MEM_WORDS = 1024
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        req_valid_i,
    input  logic        req_we_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        stall_o,
    output logic        done_o,
    output logic [31:0] load_data_o,
    output logic        err_o,
    output logic [1:0]  err_cause_o,
    output logic [31:0] mem_address_o,
    output logic [31:0] mem_datain_o,
    output logic        mem_wen_o,
    output logic        mem_ren_o,
    output logic [3:0]  mem_byte_selector_o,
    input  logic [31:0] mem_dataout_i,
    input  logic        mem_memsig_i
);

    typedef enum logic [2:0] {StIdle, StIssue, StWait, StDone, StErr} state_e;

    state_e      state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] load_data_q, load_data_d;
    logic [1:0]  cause_q, cause_d;

    logic        illegal, misaligned, out_of_range;
    logic [1:0]  lane_off;
    logic [31:0] shifted, formatted;

    // Classify the incoming request; illegal width outranks misalignment outranks range.
    always_comb begin
        if (req_we_i) begin
            illegal = req_funct3_i[2] || (req_funct3_i[1:0] == 2'b11);
        end else begin
            illegal = (req_funct3_i == 3'b011) || (req_funct3_i[2:1] == 2'b11);
        end
        misaligned = 1'b0;
`ifdef MISALIGN_TRAP_EN
        misaligned = ((req_funct3_i[1:0] == 2'b01) && req_addr_i[0]) ||
                     ((req_funct3_i[1:0] == 2'b10) && (req_addr_i[1:0] != 2'b00));
`endif
        out_of_range = {2'b00, req_addr_i[31:2]} >= MEM_WORDS;
    end

    // Byte offset of the access inside the word; bits that do not fit the width are dropped.
    always_comb begin
        case (funct3_q[1:0])
            2'b00:   lane_off = addr_q[1:0];
            2'b01:   lane_off = {addr_q[1], 1'b0};
            default: lane_off = 2'b00;
        endcase
        shifted = mem_dataout_i >> {lane_off, 3'b000};
        case (funct3_q)
            3'b000:  formatted = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  formatted = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  formatted = {24'h0, shifted[7:0]};
            3'b101:  formatted = {16'h0, shifted[15:0]};
            default: formatted = shifted;
        endcase
    end

    // Next-state logic: latch the request in IDLE and capture load data in WAIT.
    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        funct3_d    = funct3_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        load_data_d = load_data_q;
        cause_d     = cause_q;
        case (state_q)
            StIdle: begin
                if (req_valid_i) begin
                    we_d     = req_we_i;
                    funct3_d = req_funct3_i;
                    addr_d   = req_addr_i;
                    wdata_d  = req_wdata_i;
                    if (illegal) begin
                        cause_d = 2'b11;
                    end else if (misaligned) begin
                        cause_d = 2'b01;
                    end else if (out_of_range) begin
                        cause_d = 2'b10;
                    end else begin
                        cause_d = 2'b00;
                    end
                    if (illegal || misaligned || out_of_range) begin
                        load_data_d = 32'h0;
                        state_d     = StErr;
                    end else begin
                        state_d = StIssue;
                    end
                end
            end
            StIssue: state_d = we_q ? StDone : StWait;
            StWait: begin
                if (mem_memsig_i) begin
                    load_data_d = formatted;
                    state_d     = StDone;
                end
            end
            // A request still visible here is the one just completed.
            StDone:  state_d = StIdle;
            StErr:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State and request registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= StIdle;
            we_q        <= 1'b0;
            funct3_q    <= 3'b000;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            load_data_q <= 32'h0;
            cause_q     <= 2'b00;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            funct3_q    <= funct3_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            load_data_q <= load_data_d;
            cause_q     <= cause_d;
        end
    end

    // Outputs decoded from the registered state; memory signals only live in ISSUE.
    always_comb begin
        done_o              = 1'b0;
        err_o               = 1'b0;
        err_cause_o         = 2'b00;
        mem_address_o       = 32'h0;
        mem_datain_o        = 32'h0;
        mem_wen_o           = 1'b0;
        mem_ren_o           = 1'b0;
        mem_byte_selector_o = 4'b0000;
        case (state_q)
            StIssue: begin
                mem_address_o = {2'b00, addr_q[31:2]};
                if (we_q) begin
                    mem_wen_o = 1'b1;
                    case (funct3_q[1:0])
                        2'b00: begin
                            mem_byte_selector_o = 4'b0001 << lane_off;
                            mem_datain_o        = {4{wdata_q[7:0]}};
                        end
                        2'b01: begin
                            mem_byte_selector_o = 4'b0011 << lane_off;
                            mem_datain_o        = {2{wdata_q[15:0]}};
                        end
                        default: begin
                            mem_byte_selector_o = 4'b1111;
                            mem_datain_o        = wdata_q;
                        end
                    endcase
                end else begin
                    mem_ren_o = 1'b1;
                end
            end
            StDone: done_o = 1'b1;
            StErr: begin
                done_o      = 1'b1;
                err_o       = 1'b1;
                err_cause_o = cause_q;
            end
            default: ;
        endcase
    end

    assign stall_o     = req_valid_i && !done_o;
    assign load_data_o = load_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small word-addressed memory model.
module tb_load_store_unit;

    logic        clk, reset, req_valid, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        stall, done, err, mem_wen, mem_ren, mem_memsig;
    logic [1:0]  err_cause;
    logic [31:0] load_data, mem_address, mem_datain, mem_dataout;
    logic [3:0]  mem_byte_selector;

    logic        model_sig = 1'b0, stray_sig = 1'b0, block_resp = 1'b0;
    int          ren_cnt = 0, wen_cnt = 0, stall_cnt = 0, both_cnt = 0;
    logic [31:0] last_addr = 0, last_datain = 0;
    logic [3:0]  last_sel = 0;
    logic [31:0] mem [0:1023];
    int          n_pass = 0, n_total = 0;

    assign mem_memsig = model_sig | stray_sig;

    load_store_unit #(.MEM_WORDS(1024)) dut (
        .clk_i(clk), .reset_i(reset), .req_valid_i(req_valid), .req_we_i(req_we),
        .req_funct3_i(req_funct3), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .stall_o(stall), .done_o(done), .load_data_o(load_data), .err_o(err),
        .err_cause_o(err_cause), .mem_address_o(mem_address), .mem_datain_o(mem_datain),
        .mem_wen_o(mem_wen), .mem_ren_o(mem_ren), .mem_byte_selector_o(mem_byte_selector),
        .mem_dataout_i(mem_dataout), .mem_memsig_i(mem_memsig)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory model: one-cycle read response, byte-lane writes, strobe bookkeeping.
    always @(posedge clk) begin
        model_sig <= 1'b0;
        if (reset) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
            mem[4]    <= 32'hDEADBEEF;
            mem[1023] <= 32'hCAFEF00D;
            ren_cnt   <= 0;
            wen_cnt   <= 0;
        end else begin
            if (mem_ren) begin
                ren_cnt   <= ren_cnt + 1;
                last_addr <= mem_address;
                if (!block_resp) begin
                    mem_dataout <= mem[mem_address[9:0]];
                    model_sig   <= 1'b1;
                end
            end
            if (mem_wen) begin
                wen_cnt     <= wen_cnt + 1;
                last_addr   <= mem_address;
                last_sel    <= mem_byte_selector;
                last_datain <= mem_datain;
                for (int b = 0; b < 4; b++)
                    if (mem_byte_selector[b]) mem[mem_address[9:0]][8*b +: 8] <= mem_datain[8*b +: 8];
            end
        end
    end

    always @(negedge clk) begin
        if (stall) stall_cnt <= stall_cnt + 1;
        if (mem_wen && mem_ren) both_cnt <= both_cnt + 1;
    end

    // Issue one request and observe its completion; lat = 999 when done never arrives.
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, output int lat, output logic [31:0] ld,
                          output logic e, output logic [1:0] cause, output int nren,
                          output int nwen, output int nstall);
        int r0, w0, s0;
        r0 = ren_cnt; w0 = wen_cnt; s0 = stall_cnt;
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        lat = 999; ld = 32'hx; e = 1'bx; cause = 2'bx;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = i; ld = load_data; e = err; cause = err_cause;
                break;
            end
        end
        req_valid = 1'b0;
        @(posedge clk); #1;
        nren = ren_cnt - r0; nwen = wen_cnt - w0; nstall = stall_cnt - s0;
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0;
        req_addr = 32'h0; req_wdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        n_total++;
        if ({done, err, err_cause, mem_wen, mem_ren, mem_byte_selector, stall} !== 11'h0)
            $display("FAIL reset_ctrl: got %b want 0",
                     {done, err, err_cause, mem_wen, mem_ren, mem_byte_selector, stall});
        else n_pass++;
        n_total++;
        if ({load_data, mem_address, mem_datain} !== 96'h0)
            $display("FAIL reset_data: got %h want 0", {load_data, mem_address, mem_datain});
        else n_pass++;
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_loads();
        int lat, nr, nw, ns; logic [31:0] ld; logic e; logic [1:0] c;
        do_req(1'b0, 3'b000, 32'h13, 32'h0, lat, ld, e, c, nr, nw, ns);
        n_total++; if (lat !== 3) $display("FAIL lb_latency: got %0d want 3", lat); else n_pass++;
        n_total++; if (ld !== 32'hFFFFFFDE) $display("FAIL lb_data: got %h want ffffffde", ld); else n_pass++;
        n_total++; if (e !== 1'b0) $display("FAIL lb_err: got %b want 0", e); else n_pass++;
        n_total++; if (nr !== 1 || nw !== 0) $display("FAIL lb_strobes: got ren %0d wen %0d want 1 0", nr, nw); else n_pass++;
        n_total++; if (last_addr !== 32'd4) $display("FAIL lb_addr: got %h want 4", last_addr); else n_pass++;
        n_total++; if (ns !== 3) $display("FAIL lb_stall: got %0d want 3", ns); else n_pass++;
        do_req(1'b0, 3'b100, 32'h11, 32'h0, lat, ld, e, c, nr, nw, ns);
        n_total++; if (ld !== 32'h000000BE) $display("FAIL lbu_data: got %h want 000000be", ld); else n_pass++;
        do_req(1'b0, 3'b101, 32'h10, 32'h0, lat, ld, e, c, nr, nw, ns);
        n_total++; if (ld !== 32'h0000BEEF) $display("FAIL lhu_data: got %h want 0000beef", ld); else n_pass++;
        do_req(1'b0, 3'b001, 32'h12, 32'h0, lat, ld, e, c, nr, nw, ns);
        n_total++; if (ld !== 32'hFFFFDEAD) $display("FAIL lh_data: got %h want ffffdead", ld); else n_pass++;
        do_req(1'b0, 3'b010, 32'h10, 32'h0, lat, ld, e, c, nr, nw, ns);
        n_total++; if (ld !== 32'hDEADBEEF) $display("FAIL lw_data: got %h want deadbeef", ld); else n_pass++;
        do_req(1'b0, 3'b010, 32'h12, 32'h0, lat, ld, e, c, nr, nw, ns);
`ifdef MISALIGN_TRAP_EN
        n_total++; if (e !== 1'b1 || c !== 2'b01) $display("FAIL lw_misalign: got err %b cause %b want 1 01", e, c); else n_pass++;
        n_total++; if (ld !== 32'h0 || lat !== 1) $display("FAIL lw_misalign_data: got %h lat %0d want 0 1", ld, lat); else n_pass++;
        n_total++; if (nr !== 0 || nw !== 0) $display("FAIL lw_misalign_strobes: got %0d %0d want 0 0", nr, nw); else n_pass++;
`else
        n_total++; if (e !== 1'b0 || ld !== 32'hDEADBEEF) $display("FAIL lw_unaligned: got err %b data %h want 0 deadbeef", e, ld); else n_pass++;
`endif
        // Misaligned and out of range together: misalignment has priority when trapping.
        do_req(1'b0, 3'b001, 32'h1001, 32'h0, lat, ld, e, c, nr, nw, ns);
`ifdef MISALIGN_TRAP_EN
        n_total++; if (c !== 2'b01) $display("FAIL lh_mis_range_cause: got %b want 01", c); else n_pass++;
`else
        n_total++; if (c !== 2'b10) $display("FAIL lh_mis_range_cause: got %b want 10", c); else n_pass++;
`endif
    endtask

    task automatic test_stores();
        int lat, nr, nw, ns; logic [31:0] ld; logic e; logic [1:0] c;
        do_req(1'b1, 3'b000, 32'h11, 32'h00000055, lat, ld, e, c, nr, nw, ns);
        n_total++; if (lat !== 2) $display("FAIL sb_latency: got %0d want 2", lat); else n_pass++;
        n_total++; if (nw !== 1 || nr !== 0) $display("FAIL sb_strobes: got wen %0d ren %0d want 1 0", nw, nr); else n_pass++;
        n_total++; if (last_sel !== 4'b0010) $display("FAIL sb_sel: got %b want 0010", last_sel); else n_pass++;
        n_total++; if (last_datain !== 32'h55555555) $display("FAIL sb_datain: got %h want 55555555", last_datain); else n_pass++;
        n_total++; if (last_addr !== 32'd4) $display("FAIL sb_addr: got %h want 4", last_addr); else n_pass++;
        do_req(1'b0, 3'b010, 32'h10, 32'h0, lat, ld, e, c, nr, nw, ns);
        n_total++; if (ld !== 32'hDEAD55EF) $display("FAIL sb_readback: got %h want dead55ef", ld); else n_pass++;
        do_req(1'b1, 3'b001, 32'h16, 32'h1234ABCD, lat, ld, e, c, nr, nw, ns);
        n_total++; if (last_sel !== 4'b1100 || last_datain !== 32'hABCDABCD)
            $display("FAIL sh_lanes: got %b %h want 1100 abcdabcd", last_sel, last_datain); else n_pass++;
        do_req(1'b0, 3'b001, 32'h16, 32'h0, lat, ld, e, c, nr, nw, ns);
        n_total++; if (ld !== 32'hFFFFABCD) $display("FAIL sh_readback: got %h want ffffabcd", ld); else n_pass++;
        do_req(1'b1, 3'b010, 32'h18, 32'h89ABCDEF, lat, ld, e, c, nr, nw, ns);
        n_total++; if (last_sel !== 4'b1111 || last_addr !== 32'd6)
            $display("FAIL sw_lanes: got %b addr %h want 1111 6", last_sel, last_addr); else n_pass++;
        do_req(1'b0, 3'b010, 32'h18, 32'h0, lat, ld, e, c, nr, nw, ns);
        n_total++; if (ld !== 32'h89ABCDEF) $display("FAIL sw_readback: got %h want 89abcdef", ld); else n_pass++;
    endtask

    task automatic test_errors();
        int lat, nr, nw, ns; logic [31:0] ld; logic e; logic [1:0] c;
        do_req(1'b0, 3'b010, 32'h1000, 32'h0, lat, ld, e, c, nr, nw, ns);
        n_total++; if (e !== 1'b1 || c !== 2'b10) $display("FAIL range_err: got err %b cause %b want 1 10", e, c); else n_pass++;
        n_total++; if (lat !== 1 || ld !== 32'h0) $display("FAIL range_timing: got lat %0d data %h want 1 0", lat, ld); else n_pass++;
        n_total++; if (nr !== 0 || nw !== 0) $display("FAIL range_strobes: got %0d %0d want 0 0", nr, nw); else n_pass++;
        n_total++; if (ns !== 1) $display("FAIL range_stall: got %0d want 1", ns); else n_pass++;
        do_req(1'b0, 3'b010, 32'hFFC, 32'h0, lat, ld, e, c, nr, nw, ns);
        n_total++; if (e !== 1'b0 || ld !== 32'hCAFEF00D) $display("FAIL last_word: got err %b data %h want 0 cafef00d", e, ld); else n_pass++;
        do_req(1'b0, 3'b011, 32'h10, 32'h0, lat, ld, e, c, nr, nw, ns);
        n_total++; if (e !== 1'b1 || c !== 2'b11) $display("FAIL ld_f3_011: got err %b cause %b want 1 11", e, c); else n_pass++;
        do_req(1'b0, 3'b110, 32'h10, 32'h0, lat, ld, e, c, nr, nw, ns);
        n_total++; if (c !== 2'b11) $display("FAIL ld_f3_110: got %b want 11", c); else n_pass++;
        do_req(1'b1, 3'b100, 32'h10, 32'h0, lat, ld, e, c, nr, nw, ns);
        n_total++; if (c !== 2'b11 || nw !== 0) $display("FAIL st_f3_100: got cause %b wen %0d want 11 0", c, nw); else n_pass++;
        do_req(1'b1, 3'b011, 32'h2000, 32'h0, lat, ld, e, c, nr, nw, ns);
        n_total++; if (c !== 2'b11) $display("FAIL st_illegal_range: got %b want 11", c); else n_pass++;
    endtask

    task automatic test_reset_mid_wait();
        int lat, nr, nw, ns; logic [31:0] ld; logic e; logic [1:0] c;
        logic seen_done;
        block_resp = 1'b1;
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; req_valid = 1'b0; block_resp = 1'b0;
        n_total++;
        if ({done, err, err_cause, mem_wen, mem_ren, load_data, mem_address} !== 70'h0)
            $display("FAIL wait_reset_outputs: got %h want 0",
                     {done, err, err_cause, mem_wen, mem_ren, load_data, mem_address});
        else n_pass++;
        seen_done = 1'b0;
        stray_sig = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            stray_sig = 1'b0;
            seen_done = seen_done | done | mem_ren | mem_wen;
        end
        n_total++; if (seen_done !== 1'b0) $display("FAIL stray_memsig: got activity %b want 0", seen_done); else n_pass++;
        n_total++; if (load_data !== 32'h0) $display("FAIL stray_load_data: got %h want 0", load_data); else n_pass++;
        do_req(1'b0, 3'b010, 32'h10, 32'h0, lat, ld, e, c, nr, nw, ns);
        n_total++; if (lat !== 3 || ld !== 32'hDEADBEEF)
            $display("FAIL after_reset_lw: got lat %0d data %h want 3 deadbeef", lat, ld); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int r0, lat;
        r0 = ren_cnt;
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10;
        lat = 999;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (done) begin lat = i; break; end
        end
        n_total++; if (lat !== 3) $display("FAIL b2b_first_latency: got %0d want 3", lat); else n_pass++;
        // Request left asserted through DONE must not start a second access.
        @(posedge clk); #1;
        n_total++; if (done !== 1'b0 || ren_cnt - r0 !== 1)
            $display("FAIL b2b_done_ignore: got done %b reads %0d want 0 1", done, ren_cnt - r0); else n_pass++;
        req_funct3 = 3'b000; req_addr = 32'h13;
        lat = 999;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (done) begin lat = i; break; end
        end
        n_total++; if (lat !== 3 || load_data !== 32'hFFFFFFDE)
            $display("FAIL b2b_second: got lat %0d data %h want 3 ffffffde", lat, load_data); else n_pass++;
        req_valid = 1'b0;
        @(posedge clk); #1;
        n_total++; if (both_cnt !== 0) $display("FAIL both_strobes: got %0d want 0", both_cnt); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_loads();
        test_stores();
        test_errors();
        test_reset_mid_wait();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
